seg_7_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one seg_7_converter.
- Latches a packed BCD word through a load strobe and double-buffers it so a display update never tears mid-frame.
- Steps through the digits with a prescaler, inserting a blank guard interval between digits against ghosting, and drives the shared converter's 4-bit input plus one-hot active-low anode enables.
- Sits between the system-side value source and the converter/pad drivers.

---
 rtl/seg_7_scan_ctrl_if.sv | 22 ++
 rtl/seg_7_scan_ctrl.sv | 81 ++++++++
 tb/tb_seg_7_scan_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/seg_7_scan_ctrl_if.sv
// Display-side bundle for the 7-segment scan controller: value load strobe in,
// converter nibble, anode enables and commit status out.
interface seg_7_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [3:0]            bin;
  logic [DIGITS-1:0]     an;
  logic                  pending;
  logic                  frame_tick;

  modport master (
    output load, value,
    input  bin, an, pending, frame_tick
  );

  modport slave (
    input  load, value,
    output bin, an, pending, frame_tick
  );
endinterface

// File: rtl/seg_7_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits sharing one
// converter; double-buffered BCD value committed only at the frame boundary.
module seg_7_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter int DIGITS   = 4,
  parameter int GUARD    = 2,
  parameter int LZB      = 1
) (
  input logic          clk,
  input logic          rst,
  seg_7_scan_ctrl_if.slave bus
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {BLANK, SHOW} slot_e;

  logic [DW-1:0]         div_cnt, div_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [4*DIGITS-1:0]   shadow, shadow_nxt, pend_reg;
  logic                  div_wrap, wrap, commit, upper_nz;
  logic [DIGITS-1:0]     an_nxt;
  logic [3:0]            bin_nxt;
  slot_e                 slot;

  // Outputs are registered, so they are derived from the post-edge position and
  // the post-edge shadow; a commit is therefore visible in the very first slot.
  always_comb begin
    div_wrap   = (div_cnt == DW'(SCAN_DIV - 1));
    wrap       = div_wrap && (idx == IW'(DIGITS - 1));
    div_nxt    = div_wrap ? '0 : div_cnt + 1'b1;
    idx_nxt    = idx;
    if (div_wrap)
      idx_nxt  = wrap ? '0 : idx + 1'b1;
    commit     = wrap && bus.pending;
    shadow_nxt = commit ? pend_reg : shadow;

    upper_nz = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++)
      if (i >= 32'(idx_nxt) && shadow_nxt[4*i +: 4] != 4'h0)
        upper_nz = 1'b1;

    slot = BLANK;
    if (int'(div_nxt) >= GUARD && (LZB == 0 || idx_nxt == '0 || upper_nz))
      slot = SHOW;

    an_nxt  = '1;
    bin_nxt = 4'hF;
    if (slot == SHOW) begin
      an_nxt[idx_nxt] = 1'b0;
      bin_nxt         = shadow_nxt[4*idx_nxt +: 4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt        <= '0;
      idx            <= '0;
      shadow         <= '0;
      pend_reg       <= '0;
      bus.pending    <= 1'b0;
      bus.frame_tick <= 1'b0;
      bus.an         <= '1;
      bus.bin        <= 4'hF;
    end else begin
      div_cnt        <= div_nxt;
      idx            <= idx_nxt;
      shadow         <= shadow_nxt;
      bus.frame_tick <= commit;
      bus.an         <= an_nxt;
      bus.bin        <= bin_nxt;
      // A load on the wrap edge wins over the commit's clear of pending.
      if (bus.load) begin
        pend_reg    <= bus.value;
        bus.pending <= 1'b1;
      end else if (commit) begin
        bus.pending <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seg_7_scan_ctrl.sv
// Bench for seg_7_scan_ctrl: scan-position reference model plus directed
// literal checks, run against an LZB=1 and an LZB=0 instance in parallel.
module tb_seg_7_scan_ctrl;
  localparam int SD = 8;
  localparam int ND = 4;
  localparam int GD = 2;
  localparam int FRAME = SD * ND;

  logic        clk, rst, load;
  logic [15:0] value;
  int          checks = 0;
  int          fails  = 0;
  int          ticks  = 0;

  seg_7_scan_ctrl_if #(.DIGITS(ND)) if1 ();
  seg_7_scan_ctrl_if #(.DIGITS(ND)) if0 ();

  assign if1.load  = load;
  assign if1.value = value;
  assign if0.load  = load;
  assign if0.value = value;

  seg_7_scan_ctrl #(.SCAN_DIV(SD), .DIGITS(ND), .GUARD(GD), .LZB(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1));
  seg_7_scan_ctrl #(.SCAN_DIV(SD), .DIGITS(ND), .GUARD(GD), .LZB(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: frame position, displayed word, waiting word.
  int          mp       = 0;
  logic [15:0] msh      = '0;
  logic [15:0] mpend    = '0;
  bit          mpending = 0;
  bit          mtick    = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mp = 0; msh = '0; mpend = '0; mpending = 0; mtick = 0;
    end else begin
      mtick = 0;
      if (mp == FRAME - 1 && mpending) begin
        msh = mpend; mtick = 1; mpending = 0;
      end
      if (load) begin
        mpend = value; mpending = 1;
      end
      mp = (mp + 1) % FRAME;
    end
  end

  function automatic bit is_dark(int p, logic [15:0] sh, bit lzb);
    int d = p / SD;
    if (p % SD < GD) return 1;
    if (lzb && d > 0 && (sh >> (4 * d)) == 16'h0) return 1;
    return 0;
  endfunction

  function automatic logic [3:0] exp_an(int p, logic [15:0] sh, bit lzb);
    logic [3:0] m;
    if (is_dark(p, sh, lzb)) return 4'hF;
    m = 4'b0001 << (p / SD);
    return ~m;
  endfunction

  function automatic logic [3:0] exp_bin(int p, logic [15:0] sh, bit lzb);
    logic [15:0] s;
    if (is_dark(p, sh, lzb)) return 4'hF;
    s = sh >> (4 * (p / SD));
    return s[3:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (p=%0d t=%0t)", name, act, req, mp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("an_lzb1",    32'(if1.an),         32'(exp_an(mp, msh, 1)));
    chk("bin_lzb1",   32'(if1.bin),        32'(exp_bin(mp, msh, 1)));
    chk("pending",    32'(if1.pending),    32'(mpending));
    chk("frame_tick", 32'(if1.frame_tick), 32'(mtick));
    chk("an_lzb0",    32'(if0.an),         32'(exp_an(mp, msh, 0)));
    chk("bin_lzb0",   32'(if0.bin),        32'(exp_bin(mp, msh, 0)));
    if (if1.frame_tick) ticks++;
  end

  // Advance at least one cycle, then stop at the negedge where position == t.
  task automatic goto(input int t);
    int n = 0;
    @(negedge clk);
    while (mp != t && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (mp != t) begin
      fails++;
      $display("FAIL goto_timeout actual=%0d required=%0d", mp, t);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    load  = 1'b1;
    value = v;
    @(negedge clk);
    load  = 1'b0;
  endtask

  int tick0;

  initial begin
    rst = 1'b0; load = 1'b0; value = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_an",   32'(if1.an),         32'hF);
    chk("rst_bin",  32'(if1.bin),        32'hF);
    chk("rst_pend", 32'(if1.pending),    32'h0);
    chk("rst_tick", 32'(if1.frame_tick), 32'h0);
    rst = 1'b0;
    goto(2);  chk("t1_an_p2", 32'(if1.an), 32'hE); chk("t1_bin_p2", 32'(if1.bin), 32'h0);
    goto(8);  chk("t1_an_p8", 32'(if1.an), 32'hF);

    // Basic commit
    goto(3); do_load(16'h1234);
    chk("t2_pend_p4", 32'(if1.pending), 32'h1);
    goto(0);  chk("t2_tick", 32'(if1.frame_tick), 32'h1); chk("t2_pend0", 32'(if1.pending), 32'h0);
    goto(10); chk("t2_an_p10", 32'(if1.an), 32'hD); chk("t2_bin_p10", 32'(if1.bin), 32'h3);
    goto(16); chk("t2_an_p16", 32'(if1.an), 32'hF);
    goto(26); chk("t2_an_p26", 32'(if1.an), 32'h7); chk("t2_bin_p26", 32'(if1.bin), 32'h1);

    // Leading-zero blanking
    goto(5); do_load(16'h0007);
    goto(2);  chk("t3_bin7", 32'(if1.bin), 32'h7); chk("t3_an7", 32'(if1.an), 32'hE);
    goto(10); chk("t3_dark1", 32'(if1.an), 32'hF);
              chk("t3_nolzb_an", 32'(if0.an), 32'hD); chk("t3_nolzb_bin", 32'(if0.bin), 32'h0);
    goto(26); chk("t3_nolzb_an3", 32'(if0.an), 32'h7);
    goto(12); do_load(16'h0800);
    goto(0);
    goto(10); chk("t3_mid0_an", 32'(if1.an), 32'hD); chk("t3_mid0_bin", 32'(if1.bin), 32'h0);
    goto(18); chk("t3_d2_an", 32'(if1.an), 32'hB); chk("t3_d2_bin", 32'(if1.bin), 32'h8);
    goto(26); chk("t3_d3_dark", 32'(if1.an), 32'hF);

    // Overwrite before commit: one tick, last value wins
    goto(5);  do_load(16'h1111);
    goto(20); do_load(16'h2222);
    tick0 = ticks;
    goto(2);  chk("t4_bin", 32'(if1.bin), 32'h2);
    goto(31); goto(31);
    chk("t4_ticks", 32'(ticks - tick0), 32'd1);

    // Load on the wrap edge while another value is pending
    goto(5);  do_load(16'h9999);
    goto(31); do_load(16'h5555);
    chk("t5_tick1", 32'(if1.frame_tick), 32'h1); chk("t5_pend1", 32'(if1.pending), 32'h1);
    goto(2);  chk("t5_bin9", 32'(if1.bin), 32'h9);
    goto(0);  chk("t5_tick2", 32'(if1.frame_tick), 32'h1); chk("t5_pend2", 32'(if1.pending), 32'h0);
    goto(26); chk("t5_bin5", 32'(if1.bin), 32'h5);

    // Asynchronous reset mid-frame
    goto(5);  do_load(16'h1234);
    goto(20); chk("t6_pre_an", 32'(if1.an), 32'hB);
    #2 rst = 1'b1;
    #1 chk("t6_async_an1", 32'(if1.an), 32'hF); chk("t6_async_an0", 32'(if0.an), 32'hF);
       chk("t6_async_bin", 32'(if1.bin), 32'hF);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    goto(2);  chk("t6_d0_bin", 32'(if1.bin), 32'h0); chk("t6_d0_an", 32'(if1.an), 32'hE);
    goto(10); chk("t6_d1_dark", 32'(if1.an), 32'hF); chk("t6_nolzb_an", 32'(if0.an), 32'hD);
    goto(26);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
